// File: rtl/pkt_sim_pkg.sv
// Shared types for the scratchpad arbiter: FSM states, requester identities and small helpers.
package pkt_sim_pkg;

    localparam int COUNT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OWN_A = 2'd1,
        OWN_B = 2'd2
    } arb_state_t;

    typedef enum logic {
        OWNER_A = 1'b0,
        OWNER_B = 1'b1
    } owner_t;

    function automatic owner_t other_owner(input owner_t o);
        return (o == OWNER_A) ? OWNER_B : OWNER_A;
    endfunction

    function automatic arb_state_t own_state(input owner_t o);
        return (o == OWNER_A) ? OWN_A : OWN_B;
    endfunction

endpackage

// File: rtl/mem_arbiter_burst_counter.sv
// Per-owner beat counter, saturating at the burst quota.
// at_limit flags that a beat accepted now would reach the quota.
module burst_counter
    import pkt_sim_pkg::*;
(
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   clear,
    input  logic                   inc,
    input  logic [COUNT_WIDTH-1:0] limit,
    output logic                   at_limit
);

    logic [COUNT_WIDTH-1:0] count_reg;

    assign at_limit = ({1'b0, count_reg} + 9'd1) >= {1'b0, limit};

    // A clear that coincides with an accepted beat starts the new owner at one.
    always_ff @(posedge clock) begin
        if (!reset) begin
            count_reg <= '0;
        end else if (clear) begin
            count_reg <= inc ? COUNT_WIDTH'(1) : '0;
        end else if (inc && (count_reg < limit)) begin
            count_reg <= count_reg + COUNT_WIDTH'(1);
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester round-robin arbiter in front of a single-port scratchpad,
// with burst ownership, a fairness quota and one-cycle read return routing.
module mem_arbiter
    import pkt_sim_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 16,
    parameter int MAX_BURST  = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  a_req,
    input  logic                  a_last,
    input  logic                  a_we,
    input  logic [ADDR_WIDTH-1:0] a_addr,
    input  logic [DATA_WIDTH-1:0] a_wdata,
    output logic                  a_gnt,
    output logic                  a_rvalid,
    output logic [DATA_WIDTH-1:0] a_rdata,
    input  logic                  b_req,
    input  logic                  b_last,
    input  logic                  b_we,
    input  logic [ADDR_WIDTH-1:0] b_addr,
    input  logic [DATA_WIDTH-1:0] b_wdata,
    output logic                  b_gnt,
    output logic                  b_rvalid,
    output logic [DATA_WIDTH-1:0] b_rdata,
    output logic                  mem_en,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    localparam logic [COUNT_WIDTH-1:0] LIMIT = COUNT_WIDTH'(MAX_BURST);

    arb_state_t state_reg, state_next;
    owner_t     rr_reg, rr_next;
    logic       tag_valid_reg;
    owner_t     tag_owner_reg;

    logic                  grant_a, grant_b;
    owner_t                sel;
    logic                  sel_req, sel_last, sel_we, other_req;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_wdata;
    logic                  accepted, owning, release_now, at_limit;

    // Grant selection: IDLE arbitrates, an owner keeps the port while it requests.
    always_comb begin
        grant_a = 1'b0;
        grant_b = 1'b0;
        sel     = OWNER_A;
        case (state_reg)
            IDLE: begin
                if (a_req && (!b_req || rr_reg == OWNER_A)) begin
                    grant_a = 1'b1;
                    sel     = OWNER_A;
                end else if (b_req) begin
                    grant_b = 1'b1;
                    sel     = OWNER_B;
                end
            end
            OWN_A: begin
                sel     = OWNER_A;
                grant_a = a_req;
            end
            OWN_B: begin
                sel     = OWNER_B;
                grant_b = b_req;
            end
            default: ;
        endcase
    end

    assign sel_req   = (sel == OWNER_A) ? a_req   : b_req;
    assign sel_last  = (sel == OWNER_A) ? a_last  : b_last;
    assign sel_we    = (sel == OWNER_A) ? a_we    : b_we;
    assign sel_addr  = (sel == OWNER_A) ? a_addr  : b_addr;
    assign sel_wdata = (sel == OWNER_A) ? a_wdata : b_wdata;
    assign other_req = (sel == OWNER_A) ? b_req   : a_req;

    assign accepted    = grant_a | grant_b;
    assign owning      = (state_reg != IDLE);
    assign release_now = (accepted && (sel_last || (at_limit && other_req)))
                       || (owning && !sel_req);

    always_comb begin
        state_next = state_reg;
        rr_next    = rr_reg;
        if (release_now) begin
            rr_next    = other_owner(sel);
            state_next = other_req ? own_state(other_owner(sel)) : IDLE;
        end else if (accepted) begin
            state_next = own_state(sel);
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_reg     <= IDLE;
            rr_reg        <= OWNER_A;
            tag_valid_reg <= 1'b0;
            tag_owner_reg <= OWNER_A;
        end else begin
            state_reg     <= state_next;
            rr_reg        <= rr_next;
            tag_valid_reg <= accepted && !sel_we;
            tag_owner_reg <= sel;
        end
    end

    burst_counter u_burst_counter (
        .clock    (clock),
        .reset    (reset),
        .clear    (release_now || !owning),
        .inc      (accepted && !release_now),
        .limit    (LIMIT),
        .at_limit (at_limit)
    );

    // Everything is gated by reset so nothing leaks out while it is held.
    assign a_gnt     = reset & grant_a;
    assign b_gnt     = reset & grant_b;
    assign mem_en    = reset & accepted;
    assign mem_we    = mem_en & sel_we;
    assign mem_addr  = mem_en ? sel_addr  : '0;
    assign mem_wdata = mem_en ? sel_wdata : '0;

    assign a_rvalid = reset & tag_valid_reg & (tag_owner_reg == OWNER_A);
    assign b_rvalid = reset & tag_valid_reg & (tag_owner_reg == OWNER_B);
    assign a_rdata  = a_rvalid ? mem_rdata : '0;
    assign b_rdata  = b_rvalid ? mem_rdata : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: two instances (quota 8 and quota 1) share one stimulus
// stream and are both checked every cycle against a requester-level model.
module tb_mem_arbiter;

    logic        clock = 1'b0;
    logic        reset;
    logic        a_req, a_last, a_we, b_req, b_last, b_we;
    logic [15:0] a_addr, b_addr;
    logic [31:0] a_wdata, b_wdata;

    logic        a_gnt_o[2], a_rvalid_o[2], b_gnt_o[2], b_rvalid_o[2];
    logic        mem_en_o[2], mem_we_o[2];
    logic [31:0] a_rdata_o[2], b_rdata_o[2], mem_wdata_o[2], mem_rdata_i[2];
    logic [15:0] mem_addr_o[2];

    always #5 clock = ~clock;

    mem_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(16), .MAX_BURST(8)) u_dut8 (
        .clock(clock), .reset(reset),
        .a_req(a_req), .a_last(a_last), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_gnt(a_gnt_o[0]), .a_rvalid(a_rvalid_o[0]), .a_rdata(a_rdata_o[0]),
        .b_req(b_req), .b_last(b_last), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_gnt(b_gnt_o[0]), .b_rvalid(b_rvalid_o[0]), .b_rdata(b_rdata_o[0]),
        .mem_en(mem_en_o[0]), .mem_we(mem_we_o[0]), .mem_addr(mem_addr_o[0]),
        .mem_wdata(mem_wdata_o[0]), .mem_rdata(mem_rdata_i[0])
    );

    mem_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(16), .MAX_BURST(1)) u_dut1 (
        .clock(clock), .reset(reset),
        .a_req(a_req), .a_last(a_last), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_gnt(a_gnt_o[1]), .a_rvalid(a_rvalid_o[1]), .a_rdata(a_rdata_o[1]),
        .b_req(b_req), .b_last(b_last), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_gnt(b_gnt_o[1]), .b_rvalid(b_rvalid_o[1]), .b_rdata(b_rdata_o[1]),
        .mem_en(mem_en_o[1]), .mem_we(mem_we_o[1]), .mem_addr(mem_addr_o[1]),
        .mem_wdata(mem_wdata_o[1]), .mem_rdata(mem_rdata_i[1])
    );

    function automatic logic [31:0] rd_fn(input logic [15:0] a);
        return 32'(a) + 32'h90;
    endfunction

    // Scratchpad stand-in: a read returns rd_fn(addr) next cycle, otherwise noise.
    always @(posedge clock) begin
        for (int k = 0; k < 2; k++)
            mem_rdata_i[k] <= (mem_en_o[k] && !mem_we_o[k]) ? rd_fn(mem_addr_o[k]) : $urandom;
    end

    int checks = 0;
    int failures = 0;
    int cyc_n = 0;
    int lim[2] = '{8, 1};

    // Model: owner 0=none 1=A 2=B, rr 1=A 2=B, pending read (valid, owner, addr).
    int          m_owner[2], m_rr[2], m_beats[2], m_po[2];
    bit          m_pv[2];
    logic [15:0] m_pa[2];
    int          nx_owner[2], nx_rr[2], nx_beats[2], nx_po[2];
    bit          nx_pv[2];
    logic [15:0] nx_pa[2];
    int          wait_a[2], wait_b[2];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc_n, obs, exp);
        end
    endtask

    task automatic model_check(input int k);
        int g, cur, other, after;
        bit oreq, rel, g_we, g_last;
        logic [15:0] g_addr;
        logic [31:0] g_wd;
        bit e_ag, e_bg, e_en, e_we, e_arv, e_brv;
        logic [15:0] e_addr;
        logic [31:0] e_wd, e_ard, e_brd;
        string p;
        p = (k == 0) ? "q8" : "q1";
        {e_ag, e_bg, e_en, e_we, e_arv, e_brv} = '0;
        e_addr = '0; e_wd = '0; e_ard = '0; e_brd = '0;
        if (!reset) begin
            nx_owner[k] = 0; nx_rr[k] = 1; nx_beats[k] = 0;
            nx_pv[k] = 0; nx_po[k] = 0; nx_pa[k] = '0;
        end else begin
            if (m_owner[k] == 0)
                g = (a_req && b_req) ? m_rr[k] : (a_req ? 1 : (b_req ? 2 : 0));
            else
                g = ((m_owner[k] == 1 && a_req) || (m_owner[k] == 2 && b_req)) ? m_owner[k] : 0;
            g_we   = (g == 1) ? a_we   : b_we;
            g_last = (g == 1) ? a_last : b_last;
            g_addr = (g == 1) ? a_addr : b_addr;
            g_wd   = (g == 1) ? a_wdata : b_wdata;
            e_ag = (g == 1); e_bg = (g == 2); e_en = (g != 0);
            e_we = e_en && g_we;
            if (e_en) begin e_addr = g_addr; e_wd = g_wd; end
            e_arv = m_pv[k] && m_po[k] == 1;
            e_brv = m_pv[k] && m_po[k] == 2;
            if (e_arv) e_ard = rd_fn(m_pa[k]);
            if (e_brv) e_brd = rd_fn(m_pa[k]);
            nx_pv[k] = e_en && !g_we; nx_po[k] = g; nx_pa[k] = g_addr;
            nx_owner[k] = m_owner[k]; nx_rr[k] = m_rr[k]; nx_beats[k] = m_beats[k];
            cur = (m_owner[k] != 0) ? m_owner[k] : g;
            if (cur != 0) begin
                other = 3 - cur;
                oreq  = (other == 1) ? a_req : b_req;
                after = ((m_owner[k] == 0) ? 0 : m_beats[k]) + (e_en ? 1 : 0);
                if (after > lim[k]) after = lim[k];
                rel = (e_en && g_last) || (e_en && after >= lim[k] && oreq) || (m_owner[k] != 0 && g == 0);
                if (rel) begin
                    nx_rr[k] = other; nx_owner[k] = oreq ? other : 0; nx_beats[k] = 0;
                end else begin
                    nx_owner[k] = cur; nx_beats[k] = after;
                end
            end
        end
        chk({p, "_a_gnt"},     a_gnt_o[k],     e_ag);
        chk({p, "_b_gnt"},     b_gnt_o[k],     e_bg);
        chk({p, "_mem_en"},    mem_en_o[k],    e_en);
        chk({p, "_mem_we"},    mem_we_o[k],    e_we);
        chk({p, "_mem_addr"},  mem_addr_o[k],  e_addr);
        chk({p, "_mem_wdata"}, mem_wdata_o[k], e_wd);
        chk({p, "_a_rvalid"},  a_rvalid_o[k],  e_arv);
        chk({p, "_a_rdata"},   a_rdata_o[k],   e_ard);
        chk({p, "_b_rvalid"},  b_rvalid_o[k],  e_brv);
        chk({p, "_b_rdata"},   b_rdata_o[k],   e_brd);
        // Fairness: beats granted to one side while the other keeps waiting.
        if (reset && a_req && !a_gnt_o[k]) wait_a[k] += b_gnt_o[k] ? 1 : 0; else wait_a[k] = 0;
        if (reset && b_req && !b_gnt_o[k]) wait_b[k] += a_gnt_o[k] ? 1 : 0; else wait_b[k] = 0;
        chk({p, "_starve_a"}, wait_a[k] <= lim[k], 1'b1);
        chk({p, "_starve_b"}, wait_b[k] <= lim[k], 1'b1);
    endtask

    task automatic cycle_begin();
        @(negedge clock);
        model_check(0);
        model_check(1);
    endtask

    task automatic cycle_end();
        @(posedge clock);
        m_owner = nx_owner; m_rr = nx_rr; m_beats = nx_beats;
        m_pv = nx_pv; m_po = nx_po; m_pa = nx_pa;
        cyc_n++;
        #1;
    endtask

    task automatic drive(input bit ar, input bit al, input bit aw, input logic [15:0] aa, input logic [31:0] ad,
                         input bit br, input bit bl, input bit bw, input logic [15:0] ba, input logic [31:0] bd);
        a_req = ar; a_last = al; a_we = aw; a_addr = aa; a_wdata = ad;
        b_req = br; b_last = bl; b_we = bw; b_addr = ba; b_wdata = bd;
    endtask

    initial begin
        int a_cnt, b_cnt;
        bit prev_b_last;
        for (int k = 0; k < 2; k++) begin
            m_owner[k] = 0; m_rr[k] = 1; m_beats[k] = 0; m_pv[k] = 0; m_po[k] = 0; m_pa[k] = '0;
            wait_a[k] = 0; wait_b[k] = 0;
        end
        reset = 1'b0;
        drive(1, 0, 0, 16'h0001, 32'h1, 1, 0, 1, 16'h0002, 32'h2);
        // Requests held during reset must be ignored.
        for (int i = 0; i < 3; i++) begin
            cycle_begin();
            chk("rst_a_gnt", a_gnt_o[0], 1'b0);
            chk("rst_mem_en", mem_en_o[0], 1'b0);
            cycle_end();
        end
        reset = 1'b1;

        // 3-beat read burst from A with B contending; rr starts at A.
        for (int i = 0; i < 3; i++) begin
            drive(1, i == 2, 0, 16'h0010 + 16'(i), 32'h0, 1, 0, 0, 16'h0040, 32'h0);
            cycle_begin();
            chk("burst_a_gnt", a_gnt_o[0], 1'b1);
            chk("burst_b_gnt", b_gnt_o[0], 1'b0);
            chk("burst_mem_addr", mem_addr_o[0], 16'h0010 + 16'(i));
            if (i > 0) chk("burst_rdata", a_rdata_o[0], 32'hA0 + 32'(i - 1));
            cycle_end();
        end
        // B takes over immediately with a single write beat.
        drive(0, 0, 0, 16'h0, 32'h0, 1, 1, 1, 16'h0020, 32'h55);
        cycle_begin();
        chk("handover_b_gnt", b_gnt_o[0], 1'b1);
        chk("wr_mem_we", mem_we_o[0], 1'b1);
        chk("wr_mem_addr", mem_addr_o[0], 16'h0020);
        chk("wr_mem_wdata", mem_wdata_o[0], 32'h55);
        chk("last_a_rdata", a_rdata_o[0], 32'hA2);
        cycle_end();
        drive(0, 0, 0, 16'h0, 32'h0, 0, 0, 0, 16'h0, 32'h0);
        cycle_begin();
        chk("wr_no_b_rvalid", b_rvalid_o[0], 1'b0);
        cycle_end();

        // A streams 20 beats; B (3 beats) joins at A's second beat.
        a_cnt = 0; b_cnt = 0; prev_b_last = 0;
        for (int c = 0; c < 60 && a_cnt < 20; c++) begin
            drive(1, 0, 0, 16'h0100 + 16'(a_cnt), 32'h0,
                  (a_cnt >= 1) && (b_cnt < 3), b_cnt == 2, 0, 16'h0200 + 16'(b_cnt), 32'h0);
            cycle_begin();
            if (prev_b_last) chk("resume_a_gnt", a_gnt_o[0], 1'b1);
            prev_b_last = b_gnt_o[0] && b_last;
            if (b_gnt_o[0]) begin
                if (b_cnt == 0) chk("a_beats_before_b", a_cnt, 8);
                b_cnt++;
            end
            if (a_gnt_o[0]) a_cnt++;
            cycle_end();
        end
        chk("stream_a_beats", a_cnt, 20);
        chk("stream_b_beats", b_cnt, 3);

        // Quota 1: continuous contention must alternate A, B, A, B...
        reset = 1'b0;
        drive(0, 0, 0, 16'h0, 32'h0, 0, 0, 0, 16'h0, 32'h0);
        cycle_begin(); cycle_end();
        reset = 1'b1;
        for (int i = 0; i < 10; i++) begin
            drive(1, 0, 0, 16'h0300 + 16'(i), 32'h0, 1, 0, 0, 16'h0400 + 16'(i), 32'h0);
            cycle_begin();
            chk("alt_a_gnt", a_gnt_o[1], (i % 2) == 0);
            chk("alt_b_gnt", b_gnt_o[1], (i % 2) == 1);
            cycle_end();
        end

        // Reset one cycle after a read grant kills the pending return.
        reset = 1'b0;
        drive(0, 0, 0, 16'h0, 32'h0, 0, 0, 0, 16'h0, 32'h0);
        cycle_begin(); cycle_end();
        reset = 1'b1;
        drive(1, 0, 0, 16'h0030, 32'h0, 0, 0, 0, 16'h0, 32'h0);
        cycle_begin();
        chk("abort_a_gnt", a_gnt_o[0], 1'b1);
        cycle_end();
        reset = 1'b0;
        cycle_begin();
        chk("abort_rvalid_in_rst", a_rvalid_o[0], 1'b0);
        cycle_end();
        reset = 1'b1;
        drive(0, 0, 0, 16'h0, 32'h0, 0, 0, 0, 16'h0, 32'h0);
        cycle_begin();
        chk("abort_rvalid_after", a_rvalid_o[0], 1'b0);
        cycle_end();
        drive(1, 0, 0, 16'h0031, 32'h0, 1, 0, 0, 16'h0032, 32'h0);
        cycle_begin();
        chk("abort_rr_a", a_gnt_o[0], 1'b1);
        chk("abort_rr_b", b_gnt_o[0], 1'b0);
        cycle_end();

        // Random traffic with occasional resets.
        for (int i = 0; i < 800; i++) begin
            reset = ($urandom_range(0, 63) != 0);
            drive(($urandom % 4) != 0, ($urandom % 4) == 0, $urandom % 2, 16'($urandom), $urandom,
                  ($urandom % 4) != 0, ($urandom % 4) == 0, $urandom % 2, 16'($urandom), $urandom);
            cycle_begin();
            cycle_end();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, default 32: data bus width (equals MEMORY_BUS_WIDTH at instantiation).
REQ-002 Parameter ADDR_WIDTH, default 16: word address width.
REQ-003 Parameter MAX_BURST, default 8: max consecutive beats one owner keeps while the other requester waits; legal range 1..255.
REQ-004 clock  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  synchronous, active-low reset.
REQ-006 a_req  input  1  requester A (DDMA side) presents a beat.
REQ-007 a_last  input  1  current beat is the final beat of A's burst.
REQ-008 a_we  input  1  beat is a write (1) or read (0).
REQ-009 a_addr  input  ADDR_WIDTH  beat address.
REQ-010 a_wdata  input  DATA_WIDTH  write data.
REQ-011 a_gnt  output  1  beat accepted this cycle.
REQ-012 a_rvalid  output  1  a_rdata valid.
REQ-013 a_rdata  output  DATA_WIDTH  read return data.
REQ-014 b_req, b_last, b_we, b_addr, b_wdata, b_gnt, b_rvalid, b_rdata: identical to the a_* ports, for requester B (MMIO side).
REQ-015 mem_en  output  1  single-port scratchpad access strobe.
REQ-016 mem_we  output  1  write enable.
REQ-017 mem_addr  output  ADDR_WIDTH  memory address.
REQ-018 mem_wdata  output  DATA_WIDTH  memory write data.
REQ-019 mem_rdata  input  DATA_WIDTH  read data, valid exactly one cycle after a read strobe.

Function
REQ-020 The FSM SHALL have states IDLE, OWN_A and OWN_B, plus a round-robin pointer rr in {A, B}.
REQ-021 A beat SHALL be accepted when x_req && x_gnt in the same cycle; x_gnt is combinational.
REQ-022 In IDLE, x_gnt SHALL be asserted the same cycle to the sole requester, or to rr when both request; the FSM then enters OWN_x unless the accepted beat releases (REQ-025).
REQ-023 In OWN_x, x_gnt SHALL equal x_req, and the other requester's gnt SHALL be 0.
REQ-024 An 8-bit beat counter SHALL increment on each accepted beat, clear on every ownership change, and saturate at MAX_BURST.
REQ-025 Release SHALL occur on any of: an accepted beat with x_last=1; the counter reaching MAX_BURST while the other requester has req=1; x_req=0 while in OWN_x.
REQ-026 On release, rr SHALL point to the other requester, and the next state SHALL be OWN_other if other_req=1 that cycle, else IDLE.
REQ-027 mem_en SHALL equal (beat accepted); mem_we, mem_addr and mem_wdata SHALL mux from the granted requester when mem_en=1, else be 0.
REQ-028 A registered tag (valid, owner) SHALL be set on each accepted read; on the next cycle the owner's rvalid SHALL be 1 and its rdata SHALL equal mem_rdata.
REQ-029 The non-owner's rvalid SHALL be 0, and rdata SHALL be 0 whenever rvalid=0.
REQ-030 Writes SHALL produce no rvalid.
REQ-031 Back-to-back reads SHALL sustain one rvalid per cycle.
REQ-032 Read latency (gnt to rvalid) SHALL be exactly 1 cycle.
REQ-033 With MAX_BURST=1 and both requesters continuously requesting, grants SHALL strictly alternate.
REQ-034 A requester SHALL never be starved for more than MAX_BURST consecutive accepted beats of the other.

Reset
REQ-035 While reset=0 at a clock edge: state <= IDLE, rr <= A, counter <= 0, read tag <= invalid.
REQ-036 During reset, all outputs SHALL be 0 and requests SHALL be ignored.
REQ-037 Reset asserted mid-burst SHALL abort ownership and drop any pending rvalid.

Structure
REQ-038 Enums arb_state_t {IDLE, OWN_A, OWN_B} and owner_t {OWNER_A, OWNER_B} SHALL live in the shared pkt_sim_pkg.
REQ-039 The beat counter SHALL be a sub-module burst_counter (clear, inc, limit, at_limit).
REQ-040 All other logic SHALL remain in mem_arbiter; expected size is 150-250 lines of RTL.

Verification
REQ-041 After reset, both requesters request together with rr=A: a_gnt=1 and b_gnt=0 in the first cycle; mem_addr=a_addr.
REQ-042 A issues a 3-beat read burst (last on beat 3) at addr 0x10..0x12 with the memory returning 0xA0..0xA2: a_rvalid is high for 3 consecutive cycles with those values, starting 1 cycle after the first gnt; B is granted on the cycle after the last beat.
REQ-043 MAX_BURST=8, A streams 20 beats with last=0 and B requests at A's beat 2: B is granted after A's 8th beat, then A resumes after B's last beat.
REQ-044 MAX_BURST=1, both requesters request continuously for 10 cycles: the grant sequence is A, B, A, B, ...
REQ-045 B writes 0x55 to 0x20: mem_en=mem_we=1 with addr 0x20 and wdata 0x55, and no b_rvalid follows.
REQ-046 Reset is driven low during OWN_A, one cycle after a read gnt: no a_rvalid appears, and after reset the state is IDLE with rr=A.
